// File: rtl/debounced_logic_control_pkg.sv
// Shared definitions for debounced_logic_control: LED mode codes and LED channel indices.
package debounced_logic_control_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_INVERT = 2'b11
  } mode_e;

  localparam int LED_AND = 0;
  localparam int LED_OR  = 1;
  localparam int LED_XOR = 2;

endpackage

// File: rtl/debounced_logic_control_switch_debouncer.sv
// One switch bit: two-flop synchroniser followed by a consecutive-mismatch debounce counter.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values, as real hardware does.
    if (rst_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= sw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/debounced_logic_control.sv
// N-input switch debouncer driving three registered LEDs (AND/OR/XOR) through a four-mode mux,
// with a one-cycle CHANGE pulse whenever the debounced vector moves.
module debounced_logic_control
  import debounced_logic_control_pkg::*;
#(
  parameter int N_IN            = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic [N_IN-1:0] SW,
  input  logic [1:0]      MODE,
  output logic [2:0]      LED,
  output logic            CHANGE
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [N_IN-1:0] stable;
  logic [N_IN-1:0] stable_prev_q;
  logic [2:0]      f;
  logic [2:0]      f_prev_q;
  logic [2:0]      led_q, led_d;
  logic            change_q, change_d;

  for (genvar g = 0; g < N_IN; g++) begin : g_deb
    switch_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk_i   (CLOCK),
      .rst_i   (RESET),
      .sw_i    (SW[g]),
      .stable_o(stable[g])
    );
  end

  always_comb begin
    f          = '0;
    f[LED_AND] = &stable;
    f[LED_OR]  = |stable;
    f[LED_XOR] = ^stable;

    // Compare whole vectors: several bits settling together give a single pulse.
    change_d = (stable != stable_prev_q);

    led_d = led_q;
    case (mode_e'(MODE))
      MODE_DIRECT: led_d = f;
      MODE_TOGGLE: led_d = led_q ^ (f & ~f_prev_q);
      MODE_HOLD:   led_d = led_q;
      MODE_INVERT: led_d = ~f;
      default:     led_d = led_q;
    endcase
  end

  // f_prev follows F in every mode, so entering TOGGLE never sees a stale rising edge.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      stable_prev_q <= '0;
      f_prev_q      <= '0;
      led_q         <= '0;
      change_q      <= 1'b0;
    end else begin
      stable_prev_q <= stable;
      f_prev_q      <= f;
      led_q         <= led_d;
      change_q      <= change_d;
    end
  end

  assign LED    = led_q;
  assign CHANGE = change_q;

endmodule
